multdiv_sequencer: RTL and testbench

//  Sequences the multi-cycle multiplier/divider for R-type mul (ALU op 00110) and div (00111).

---
 rtl/multdiv_sequencer.sv | 111 +++++++++++
 tb/tb_multdiv_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Control sequencer for the multi-cycle multiply/divide unit: stalls fetch,
// pulses the start strobe, waits for ready or timeout, then issues one writeback.
module multdiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_Rtype,
  input  logic [4:0]  aluOp,
  input  logic [4:0]  rd,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        md_we,
  output logic [4:0]  md_wr_reg,
  output logic [31:0] md_wr_data,
  output logic        timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_COMMIT} state_t;

  localparam logic [4:0]       OP_MUL   = 5'b00110;
  localparam logic [4:0]       OP_DIV   = 5'b00111;
  localparam logic [4:0]       EXC_REG  = 5'd30;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              op_mul_q, op_mul_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       result_q, result_d;
  logic              exc_q, exc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              req;

  assign req = is_Rtype & ((aluOp == OP_MUL) | (aluOp == OP_DIV));

  always_comb begin
    state_d       = state_q;
    op_mul_d      = op_mul_q;
    rd_d          = rd_q;
    result_d      = result_q;
    exc_d         = exc_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_mul_d = (aluOp == OP_MUL);
          rd_d     = rd;
          exc_d    = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // a ready arriving on the final wait cycle beats the timeout
        if (md_ready) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = S_COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          exc_d         = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_mul_q      <= 1'b0;
      rd_q          <= '0;
      result_q      <= '0;
      exc_q         <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_mul_q      <= op_mul_d;
      rd_q          <= rd_d;
      result_q      <= result_d;
      exc_q         <= exc_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // IDLE stall is combinational so the PC holds on the request edge itself
  assign stall       = ~reset & (((state_q == S_IDLE) & req) |
                                 (state_q == S_START) | (state_q == S_WAIT));
  assign ctrl_MULT   = (state_q == S_START) &  op_mul_q;
  assign ctrl_DIV    = (state_q == S_START) & ~op_mul_q;
  assign md_we       = (state_q == S_COMMIT) & (exc_q | (rd_q != 5'd0));
  assign md_wr_reg   = (state_q != S_COMMIT) ? 5'd0 : (exc_q ? EXC_REG : rd_q);
  assign md_wr_data  = (state_q != S_COMMIT) ? 32'd0 :
                       (exc_q ? (op_mul_q ? 32'd4 : 32'd5) : result_q);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: drives on the falling edge, checks before the rising edge.
module tb_multdiv_sequencer;
  localparam int TO = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        is_Rtype;
  logic [4:0]  aluOp;
  logic [4:0]  rd;
  logic [31:0] md_result;
  logic        md_ready;
  logic        md_exception;
  logic        ctrl_MULT, ctrl_DIV, stall, md_we, timeout_err;
  logic [4:0]  md_wr_reg;
  logic [31:0] md_wr_data;

  int errors = 0;
  int checks = 0;

  multdiv_sequencer #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .is_Rtype(is_Rtype), .aluOp(aluOp), .rd(rd),
    .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall), .md_we(md_we),
    .md_wr_reg(md_wr_reg), .md_wr_data(md_wr_data), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Issues one request and records what the DUT does; n<0 means md_ready never arrives.
  task automatic do_op(input logic [4:0] op, input logic [4:0] r, input int n,
                       input logic [31:0] res, input logic exc,
                       output int we_cnt, output int mul_cnt, output int div_cnt,
                       output logic [4:0] wreg, output logic [31:0] wdata,
                       output int lat, output logic stall0);
    int s;
    s = -1; lat = -1; we_cnt = 0; mul_cnt = 0; div_cnt = 0; wreg = 'x; wdata = 'x;
    @(negedge clock);
    is_Rtype = 1'b1; aluOp = op; rd = r;
    #1 stall0 = stall;
    for (int c = 1; c <= TO + 10; c++) begin
      @(negedge clock);
      is_Rtype = 1'b0; aluOp = 5'd0; rd = 5'd0;
      md_ready = 1'b0; md_exception = 1'b0; md_result = 32'hDEAD_BEEF;
      #1;
      if (ctrl_MULT) begin mul_cnt++; if (s < 0) s = c; end
      if (ctrl_DIV)  begin div_cnt++; if (s < 0) s = c; end
      if (md_we) we_cnt++;
      if (s >= 0 && c > s && !stall && lat < 0) begin
        lat = c; wreg = md_wr_reg; wdata = md_wr_data;
      end
      if (s >= 0 && n >= 0 && c - s == n) begin
        md_ready = 1'b1; md_exception = exc; md_result = res;
      end
      if (lat >= 0 && c >= lat + 2) break;
    end
    @(negedge clock);
    md_ready = 1'b0; md_exception = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; is_Rtype = 1'b1; aluOp = 5'b00110; rd = 5'd3;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++; if ({ctrl_MULT, ctrl_DIV, md_we} !== 3'b000) begin errors++; $display("FAIL rst_ctrl got=%b exp=000", {ctrl_MULT, ctrl_DIV, md_we}); end
    checks++; if ({md_wr_reg, md_wr_data, timeout_err} !== 38'd0) begin errors++; $display("FAIL rst_wb got=%h/%h/%b exp=0", md_wr_reg, md_wr_data, timeout_err); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rel_stall got=%b exp=1", stall); end
    checks++; if (ctrl_MULT !== 1'b0) begin errors++; $display("FAIL rel_mult_early got=%b exp=0", ctrl_MULT); end
    @(negedge clock);
    is_Rtype = 1'b0;
    #1;
    checks++; if ({ctrl_MULT, ctrl_DIV, stall} !== 3'b101) begin errors++; $display("FAIL rel_start got=%b exp=101", {ctrl_MULT, ctrl_DIV, stall}); end
    @(negedge clock);
    md_ready = 1'b1; md_result = 32'h0000_0011;
    @(negedge clock);
    md_ready = 1'b0;
    #1;
    checks++; if ({md_we, stall} !== 2'b10) begin errors++; $display("FAIL rel_commit got=%b exp=10", {md_we, stall}); end
    checks++; if ({md_wr_reg, md_wr_data} !== {5'd3, 32'h11}) begin errors++; $display("FAIL rel_wb got=%0d/%h exp=3/11", md_wr_reg, md_wr_data); end
  endtask

  task automatic test_mul;
    int we, mc, dc, lat; logic [4:0] wr; logic [31:0] wd; logic s0;
    do_op(5'b00110, 5'd5, 17, 32'h0000_0C00, 1'b0, we, mc, dc, wr, wd, lat, s0);
    checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL mul_req_stall got=%b exp=1", s0); end
    checks++; if (mc !== 1 || dc !== 0) begin errors++; $display("FAIL mul_pulses got=%0d/%0d exp=1/0", mc, dc); end
    checks++; if (we !== 1) begin errors++; $display("FAIL mul_we_count got=%0d exp=1", we); end
    checks++; if (wr !== 5'd5 || wd !== 32'hC00) begin errors++; $display("FAIL mul_wb got=%0d/%h exp=5/c00", wr, wd); end
    checks++; if (lat !== 19) begin errors++; $display("FAIL mul_latency got=%0d exp=19", lat); end
  endtask

  task automatic test_exception;
    int we, mc, dc, lat; logic [4:0] wr; logic [31:0] wd; logic s0;
    do_op(5'b00111, 5'd7, 3, 32'h1234_5678, 1'b1, we, mc, dc, wr, wd, lat, s0);
    checks++; if (mc !== 0 || dc !== 1) begin errors++; $display("FAIL div_pulses got=%0d/%0d exp=0/1", mc, dc); end
    checks++; if (we !== 1 || wr !== 5'd30 || wd !== 32'd5) begin errors++; $display("FAIL div_exc got=%0d/%0d/%0d exp=1/30/5", we, wr, wd); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL div_latency got=%0d exp=5", lat); end
    do_op(5'b00110, 5'd0, 1, 32'h0, 1'b1, we, mc, dc, wr, wd, lat, s0);
    checks++; if (we !== 1 || wr !== 5'd30 || wd !== 32'd4) begin errors++; $display("FAIL mul_exc got=%0d/%0d/%0d exp=1/30/4", we, wr, wd); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL exc_no_toerr got=%b exp=0", timeout_err); end
  endtask

  task automatic test_rd_zero;
    int we, mc, dc, lat; logic [4:0] wr; logic [31:0] wd; logic s0;
    do_op(5'b00110, 5'd0, 4, 32'h0000_00AA, 1'b0, we, mc, dc, wr, wd, lat, s0);
    checks++; if (we !== 0) begin errors++; $display("FAIL rd0_we got=%0d exp=0", we); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL rd0_release got=%0d exp=6", lat); end
  endtask

  task automatic test_timeout;
    int we, mc, dc, lat; logic [4:0] wr; logic [31:0] wd; logic s0;
    do_op(5'b00111, 5'd9, TO, 32'h0000_0042, 1'b0, we, mc, dc, wr, wd, lat, s0);
    checks++; if (we !== 1 || wr !== 5'd9 || wd !== 32'h42) begin errors++; $display("FAIL last_cycle_wb got=%0d/%0d/%h exp=1/9/42", we, wr, wd); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL last_cycle_err got=%b exp=0", timeout_err); end
    checks++; if (lat !== TO + 2) begin errors++; $display("FAIL last_cycle_lat got=%0d exp=%0d", lat, TO + 2); end
    do_op(5'b00110, 5'd11, -1, 32'h0, 1'b0, we, mc, dc, wr, wd, lat, s0);
    checks++; if (we !== 1 || wr !== 5'd30 || wd !== 32'd4) begin errors++; $display("FAIL to_wb got=%0d/%0d/%0d exp=1/30/4", we, wr, wd); end
    checks++; if (lat !== TO + 2) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", lat, TO + 2); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", timeout_err); end
  endtask

  task automatic test_reset_mid_wait;
    int we_cnt, stall_cnt, pulse_cnt;
    we_cnt = 0; stall_cnt = 0; pulse_cnt = 0;
    @(negedge clock);
    is_Rtype = 1'b1; aluOp = 5'b00111; rd = 5'd12;
    @(negedge clock);
    is_Rtype = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checks++; if ({stall, ctrl_MULT, ctrl_DIV, md_we} !== 4'b0000) begin errors++; $display("FAIL midrst_outs got=%b exp=0000", {stall, ctrl_MULT, ctrl_DIV, md_we}); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", timeout_err); end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      md_ready = (c == 1); md_exception = (c == 1); md_result = 32'h77;
      #1;
      if (md_we) we_cnt++;
      if (stall) stall_cnt++;
      if (ctrl_MULT | ctrl_DIV) pulse_cnt++;
    end
    md_ready = 1'b0; md_exception = 1'b0;
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL midrst_we got=%0d exp=0", we_cnt); end
    checks++; if (stall_cnt !== 0 || pulse_cnt !== 0) begin errors++; $display("FAIL idle_stray got=%0d/%0d exp=0/0", stall_cnt, pulse_cnt); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_exception();
    test_rd_zero();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
